// File: rtl/acceso_pkg.sv
// Shared definitions for the parking-entrance gate controller.
//   - One-hot state encodings (ST_*) and their bit positions (B_*).
//   - ancho_cnt(): width of a down-counter able to hold the larger of two
//     cycle counts.
package acceso_pkg;

    // Bit position of each state inside the one-hot state vector.
    localparam int B_IDLE     = 0;
    localparam int B_PIN      = 1;
    localparam int B_OPEN     = 2;
    localparam int B_CLOSE    = 3;
    localparam int B_LOCK     = 4;
    localparam int B_TAILGATE = 5;

    localparam logic [5:0] ST_IDLE     = 6'b000001;
    localparam logic [5:0] ST_PIN      = 6'b000010;
    localparam logic [5:0] ST_OPEN     = 6'b000100;
    localparam logic [5:0] ST_CLOSE    = 6'b001000;
    localparam logic [5:0] ST_LOCK     = 6'b010000;
    localparam logic [5:0] ST_TAILGATE = 6'b100000;

    // Width needed to hold max(a, b); never less than 1 bit.
    function automatic int ancho_cnt(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/contador_desc.sv
// Loadable down-counter with a zero flag.
// Ports:
//   Clk, Reset : clock (rising edge), asynchronous active-high reset
//   Cargar     : load Valor (has priority over Dec)
//   Valor      : value to load
//   Dec        : decrement by one; holds at zero
//   Cero       : count is zero
module contador_desc #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Cargar,
    input  logic [W-1:0] Valor,
    input  logic         Dec,
    output logic         Cero
);

    logic [W-1:0] cuenta;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cuenta <= '0;
        end else if (Cargar) begin
            cuenta <= Valor;
        end else if (Dec && (cuenta != '0)) begin
            cuenta <= cuenta - W'(1);
        end
    end

    assign Cero = (cuenta == '0);

endmodule

// File: rtl/controlador_acceso_param.sv
// Parking-entrance gate controller (one-hot Moore FSM).
// A vehicle at the entry sensor starts a PIN session; the correct BCD PIN
// opens the gate, MAX_INTENTOS wrong PINs lock the keypad for LOCK_CYCLES
// (0 = until Reset). An open gate closes when the vehicle passes or after
// OPEN_TIMEOUT cycles; a second vehicle behind the first raises the
// tailgate alarm, cleared only by a correct guard code.
// Ports:
//   Clk, Reset        : clock (rising edge), asynchronous active-high reset
//   Entrada, Salida   : entry / past-gate vehicle sensors
//   Enter, Clave      : keypad enter (level) and BCD PIN
//   Abrir, Cerrar     : gate actuator commands
//   AlrmInt, AlrmCom  : lockout alarm, tailgate alarm
//   Intentos          : current wrong-attempt count
//   Autos             : vehicles admitted since reset (saturating)
//   Estado            : raw one-hot state vector, for debug/observation
module controlador_acceso_param
    import acceso_pkg::*;
#(
    parameter int                    DIGITS       = 4,
    parameter logic [4*DIGITS-1:0]   CLAVE_VALIDA = 16'h0259,
    parameter int                    MAX_INTENTOS = 3,
    parameter int                    OPEN_TIMEOUT = 1000,
    parameter int                    LOCK_CYCLES  = 5000,
    parameter int                    CNT_W        = 8
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              Entrada,
    input  logic                              Salida,
    input  logic                              Enter,
    input  logic [4*DIGITS-1:0]               Clave,
    output logic                              Abrir,
    output logic                              Cerrar,
    output logic                              AlrmInt,
    output logic                              AlrmCom,
    output logic [$clog2(MAX_INTENTOS+1)-1:0] Intentos,
    output logic [CNT_W-1:0]                  Autos,
    output logic [5:0]                        Estado
);

    localparam int IW = $clog2(MAX_INTENTOS + 1);
    localparam int TW = ancho_cnt(OPEN_TIMEOUT, LOCK_CYCLES);

    localparam logic [TW-1:0] CARGA_OPEN = TW'(OPEN_TIMEOUT - 1);
    // With LOCK_CYCLES == 0 the lock timer is never consulted.
    localparam logic [TW-1:0] CARGA_LOCK = (LOCK_CYCLES == 0) ? '0 : TW'(LOCK_CYCLES - 1);
    localparam logic [IW-1:0] INT_MAX    = IW'(MAX_INTENTOS);

    // Input stage
    logic                entrada_q, salida_q, enter_q, enter_q2;
    logic [4*DIGITS-1:0] clave_q;
    logic                enter_p, match;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            entrada_q <= 1'b0;
            salida_q  <= 1'b0;
            enter_q   <= 1'b0;
            enter_q2  <= 1'b0;
            clave_q   <= '0;
        end else begin
            entrada_q <= Entrada;
            salida_q  <= Salida;
            enter_q   <= Enter;
            enter_q2  <= enter_q;
            clave_q   <= Clave;
        end
    end

    // One attempt per press, however long Enter is held.
    assign enter_p = enter_q & ~enter_q2;
    assign match   = (clave_q == CLAVE_VALIDA);

    // FSM and counters
    logic [5:0]       state, state_n;
    logic [IW-1:0]    intentos, intentos_n, intentos_inc;
    logic [CNT_W-1:0] autos;
    logic             autos_inc;
    logic             open_load, open_dec, open_zero;
    logic             lock_load, lock_dec, lock_zero;

    assign intentos_inc = intentos + IW'(1);

    always_comb begin
        state_n    = state;
        intentos_n = intentos;
        autos_inc  = 1'b0;
        open_load  = 1'b0;
        open_dec   = 1'b0;
        lock_load  = 1'b0;
        lock_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                intentos_n = '0;
                if (entrada_q) begin
                    state_n = ST_PIN;
                end
            end
            ST_PIN: begin
                // A press wins over the vehicle leaving in the same cycle.
                if (enter_p) begin
                    if (match) begin
                        state_n    = ST_OPEN;
                        intentos_n = '0;
                        open_load  = 1'b1;
                    end else begin
                        intentos_n = intentos_inc;
                        if (intentos_inc == INT_MAX) begin
                            state_n   = ST_LOCK;
                            lock_load = 1'b1;
                        end
                    end
                end else if (!entrada_q) begin
                    state_n    = ST_IDLE;
                    intentos_n = '0;
                end
            end
            ST_OPEN: begin
                if (salida_q && entrada_q) begin
                    state_n = ST_TAILGATE;
                end else if (salida_q) begin
                    state_n   = ST_CLOSE;
                    autos_inc = 1'b1;
                end else if (open_zero) begin
                    state_n = ST_CLOSE;
                end else begin
                    open_dec = 1'b1;
                end
            end
            ST_CLOSE: begin
                state_n = ST_IDLE;
            end
            ST_LOCK: begin
                // Keypad is ignored here; Intentos stays at MAX_INTENTOS.
                if (LOCK_CYCLES != 0) begin
                    if (lock_zero) begin
                        state_n    = ST_IDLE;
                        intentos_n = '0;
                    end else begin
                        lock_dec = 1'b1;
                    end
                end
            end
            ST_TAILGATE: begin
                // Only the guard code clears the alarm; wrong codes are ignored.
                if (enter_p && match) begin
                    state_n    = ST_IDLE;
                    intentos_n = '0;
                end
            end
            default: begin
                // Non-one-hot vectors recover to IDLE.
                state_n    = ST_IDLE;
                intentos_n = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            intentos <= '0;
            autos    <= '0;
        end else begin
            state    <= state_n;
            intentos <= intentos_n;
            if (autos_inc && (autos != '1)) begin
                autos <= autos + CNT_W'(1);
            end
        end
    end

    contador_desc #(.W(TW)) u_timer_open (
        .Clk    (Clk),
        .Reset  (Reset),
        .Cargar (open_load),
        .Valor  (CARGA_OPEN),
        .Dec    (open_dec),
        .Cero   (open_zero)
    );

    contador_desc #(.W(TW)) u_timer_lock (
        .Clk    (Clk),
        .Reset  (Reset),
        .Cargar (lock_load),
        .Valor  (CARGA_LOCK),
        .Dec    (lock_dec),
        .Cero   (lock_zero)
    );

    // Moore outputs straight from the state flops.
    assign Abrir    = state[B_OPEN];
    assign Cerrar   = state[B_CLOSE] | state[B_TAILGATE];
    assign AlrmInt  = state[B_LOCK];
    assign AlrmCom  = state[B_TAILGATE];
    assign Intentos = intentos;
    assign Autos    = autos;
    assign Estado   = state;

endmodule

// File: tb/tb_controlador_acceso_param.sv
// Directed + randomized bench for controlador_acceso_param.
// Expectations come from a session-level model: saturating admission count,
// wrong-attempt tally per session, and fixed open/lock durations.
module tb_controlador_acceso_param;
    import acceso_pkg::*;

    localparam int          DIGITS = 4;
    localparam logic [15:0] CLAVE  = 16'h0259;
    localparam int          MAXI   = 3;
    localparam int          OPEN_T = 8;
    localparam int          LOCK_C = 16;
    localparam int          CNT_W  = 2;
    localparam int          AUTOS_MAX = (1 << CNT_W) - 1;

    logic              Clk = 1'b0;
    logic              Reset, Entrada, Salida, Enter;
    logic [15:0]       Clave;
    logic              Abrir, Cerrar, AlrmInt, AlrmCom;
    logic [1:0]        Intentos;
    logic [CNT_W-1:0]  Autos;
    logic [5:0]        Estado;

    controlador_acceso_param #(
        .DIGITS(DIGITS), .CLAVE_VALIDA(CLAVE), .MAX_INTENTOS(MAXI),
        .OPEN_TIMEOUT(OPEN_T), .LOCK_CYCLES(LOCK_C), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Entrada(Entrada), .Salida(Salida),
        .Enter(Enter), .Clave(Clave), .Abrir(Abrir), .Cerrar(Cerrar),
        .AlrmInt(AlrmInt), .AlrmCom(AlrmCom), .Intentos(Intentos),
        .Autos(Autos), .Estado(Estado)
    );

    // Clock / watchdog
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int errors = 0;
    int checks = 0;
    int model_autos = 0;
    int model_int = 0;
    logic [CNT_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [15:0] rand_wrong();
        logic [15:0] c;
        do begin
            for (int i = 0; i < 4; i++) c[4*i +: 4] = 4'($urandom_range(0, 9));
        end while (c == CLAVE);
        return c;
    endfunction

    task automatic press(input logic [15:0] c);
        Clave = c;
        Enter = 1'b1;
        tick();
        Enter = 1'b0;
        tick();
    endtask

    task automatic go_pin();
        Entrada = 1'b1;
        tick();
        tick();
        model_int = 0;
        check("pin_state", Estado, ST_PIN);
    endtask

    task automatic drop_to_idle();
        Entrada = 1'b0;
        Salida  = 1'b0;
        tick();
        tick();
        tick();
        check("idle_state", Estado, ST_IDLE);
    endtask

    // From PIN: correct code, vehicle passes, gate closes for one cycle.
    task automatic finish_admit();
        press(CLAVE);
        check("admit_abrir", Abrir, 1);
        check("admit_intentos", Intentos, 0);
        repeat ($urandom_range(0, 3)) tick();
        Salida  = 1'b1;
        Entrada = 1'b0;
        tick();
        tick();
        check("admit_cerrar", Cerrar, 1);
        model_autos = (model_autos + 1 > AUTOS_MAX) ? AUTOS_MAX : model_autos + 1;
        exp_q.push_back(CNT_W'(model_autos));
        check("admit_autos", Autos, exp_q.pop_front());
        Salida = 1'b0;
        tick();
        check("admit_cerrar_1cyc", Cerrar, 0);
        check("admit_idle", Estado, ST_IDLE);
    endtask

    task automatic lock_up();
        for (int i = 1; i <= MAXI; i++) begin
            press(rand_wrong());
            model_int++;
            check("wrong_intentos", Intentos, model_int);
        end
        check("lock_alarm", AlrmInt, 1);
    endtask

    initial begin
        int cnt;
        Reset = 1'b1; Entrada = 1'b0; Salida = 1'b0; Enter = 1'b0; Clave = '0;
        repeat (3) tick();
        check("reset_outputs", {Abrir, Cerrar, AlrmInt, AlrmCom}, 0);
        check("reset_intentos", Intentos, 0);
        check("reset_autos", Autos, 0);
        check("reset_state", Estado, ST_IDLE);
        Reset = 1'b0;
        tick();

        // Normal admission
        go_pin();
        finish_admit();

        // Lockout: three wrong codes, timed alarm, correct code ignored
        go_pin();
        lock_up();
        cnt = 0;
        while (AlrmInt === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 2) check("lock_intentos_hold", Intentos, MAXI);
            if (cnt == 4) begin Clave = CLAVE; Enter = 1'b1; end
            if (cnt == 5) Enter = 1'b0;
            tick();
        end
        check("lock_length", cnt, LOCK_C);
        check("lock_exit_state", Estado, ST_IDLE);
        check("lock_exit_intentos", Intentos, 0);
        drop_to_idle();

        // Gate timeout without a passing vehicle
        go_pin();
        press(CLAVE);
        cnt = 0;
        while (Abrir === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        check("timeout_length", cnt, OPEN_T);
        check("timeout_cerrar", Cerrar, 1);
        check("timeout_autos", Autos, model_autos);
        tick();
        check("timeout_cerrar_1cyc", Cerrar, 0);
        drop_to_idle();

        // Tailgate
        go_pin();
        press(CLAVE);
        Salida = 1'b1;
        tick();
        tick();
        check("tail_alrmcom", AlrmCom, 1);
        check("tail_cerrar", Cerrar, 1);
        check("tail_abrir", Abrir, 0);
        Salida = 1'b0;
        press(rand_wrong());
        check("tail_wrong_keeps", {AlrmCom, Cerrar}, 2'b11);
        press(CLAVE);
        check("tail_clear_state", Estado, ST_IDLE);
        check("tail_clear_outputs", {Abrir, Cerrar, AlrmInt, AlrmCom}, 0);
        check("tail_autos", Autos, model_autos);
        drop_to_idle();

        // Enter held for many cycles counts once
        go_pin();
        Clave = rand_wrong();
        Enter = 1'b1;
        repeat (10) tick();
        Enter = 1'b0;
        tick();
        check("held_enter_intentos", Intentos, 1);
        drop_to_idle();
        check("leave_clears_intentos", Intentos, 0);

        // Five admissions saturate the counter
        repeat (5) begin
            go_pin();
            finish_admit();
        end
        check("autos_saturated", Autos, AUTOS_MAX);

        // Random sessions: a few wrong codes, then admit or walk away
        repeat (6) begin
            int k;
            k = $urandom_range(0, MAXI - 1);
            go_pin();
            for (int j = 0; j < k; j++) begin
                press(rand_wrong());
                model_int++;
                check("rand_intentos", Intentos, model_int);
            end
            if ($urandom_range(0, 1) == 1) begin
                finish_admit();
            end else begin
                drop_to_idle();
                check("rand_leave_intentos", Intentos, 0);
            end
        end

        // Asynchronous reset mid-LOCK
        go_pin();
        lock_up();
        repeat ($urandom_range(1, 5)) tick();
        Reset = 1'b1;
        #2;
        model_autos = 0;
        check("rst_lock_outputs", {Abrir, Cerrar, AlrmInt, AlrmCom}, 0);
        check("rst_lock_intentos", Intentos, 0);
        check("rst_lock_autos", Autos, model_autos);
        check("rst_lock_state", Estado, ST_IDLE);
        Entrada = 1'b0;
        tick();
        Reset = 1'b0;
        tick();

        // Asynchronous reset mid-OPEN, after one admission
        go_pin();
        finish_admit();
        go_pin();
        press(CLAVE);
        tick();
        check("pre_rst_open_abrir", Abrir, 1);
        Reset = 1'b1;
        #2;
        model_autos = 0;
        check("rst_open_outputs", {Abrir, Cerrar, AlrmInt, AlrmCom}, 0);
        check("rst_open_intentos", Intentos, 0);
        check("rst_open_autos", Autos, model_autos);
        check("rst_open_state", Estado, ST_IDLE);
        Entrada = 1'b0;
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        check("post_rst_state", Estado, ST_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controlador_acceso_param.md
Name: controlador_acceso_param

Overview:
- Parametrised parking-entrance gate controller with a one-hot Moore FSM.
- Accepts a BCD PIN of DIGITS digits, with a configurable number of wrong attempts before lockout.
- Adds three timers: gate-open timeout, timed lockout, and a saturating vehicle counter.
- Sits between the entrance sensors/keypad and the gate actuator/alarm drivers.

Parameters:
- DIGITS, 4, number of BCD digits in the PIN; Clave width = 4*DIGITS.
- CLAVE_VALIDA, 16'h0259, correct PIN, 4*DIGITS bits, BCD.
- MAX_INTENTOS, 3, wrong entries (>=1) that trigger lockout.
- OPEN_TIMEOUT, 1000, cycles the gate stays open without a Salida event before auto-close (>=1).
- LOCK_CYCLES, 5000, lockout duration in cycles; 0 = permanent until Reset.
- CNT_W, 8, width of the vehicle counter.

Ports:
- Clk  input  1  system clock, rising edge active
- Reset  input  1  asynchronous, active-high; returns all state to reset values
- Entrada  input  1  vehicle present at entry sensor
- Salida  input  1  vehicle past gate sensor
- Enter  input  1  keypad enter (level; edge-detected internally)
- Clave  input  4*DIGITS  BCD PIN from keypad
- Abrir  output  1  open gate
- Cerrar  output  1  close gate
- AlrmInt  output  1  wrong-PIN lockout alarm
- AlrmCom  output  1  tailgate alarm
- Intentos  output  $clog2(MAX_INTENTOS+1)  current wrong-attempt count
- Autos  output  CNT_W  vehicles admitted since reset, saturating

Behaviour:
- Interface:
  - One clock, Clk.
  - Reset is asynchronous and active-high, named Reset.
  - All flops clear on Reset.
- Input stage:
  - Entrada, Salida, Enter and Clave are registered on the Clk rising edge (_q).
  - A second Enter flop gives EnterP = Enter_q & ~Enter_q2, so there is one attempt per press.
  - Match = (Clave_q == CLAVE_VALIDA).
  - Input-to-state latency: 1 cycle after sampling (2 edges from pin change).
- States (one-hot): IDLE, PIN, OPEN, CLOSE, LOCK, TAILGATE. Reset state is IDLE.
- IDLE:
  - Entrada_q -> PIN, with Intentos=0.
- PIN:
  - EnterP & Match -> OPEN; Intentos=0; timer=OPEN_TIMEOUT-1.
  - EnterP & !Match:
    - Intentos+1.
    - If the new value == MAX_INTENTOS -> LOCK; timer=LOCK_CYCLES-1. Intentos holds MAX_INTENTOS during LOCK.
  - No EnterP & !Entrada_q (car left) -> IDLE; Intentos=0.
  - EnterP has priority over Entrada_q dropping in the same cycle.
- OPEN:
  - Salida_q & Entrada_q -> TAILGATE (priority 1).
  - Salida_q & !Entrada_q -> CLOSE; Autos+1, saturating at all-ones.
  - Otherwise, timer==0 -> CLOSE with no Autos change; else timer decrements.
- CLOSE:
  - Lasts exactly 1 cycle, then IDLE.
- LOCK:
  - If LOCK_CYCLES==0, hold until Reset.
  - Otherwise, decrement timer; at timer==0 -> IDLE with Intentos=0.
  - Enter is ignored in LOCK.
- TAILGATE:
  - EnterP & Match (guard code) -> IDLE; Intentos=0. Wrong codes are ignored.
- Outputs (Moore, decoded from state flops only; no glitches from inputs):
  - Abrir = OPEN.
  - Cerrar = CLOSE | TAILGATE.
  - AlrmInt = LOCK.
  - AlrmCom = TAILGATE.
- Reset values: all outputs 0, Intentos=0, Autos=0.
- Illegal or non-one-hot state -> IDLE next cycle.
- Reset mid-operation (any state, including LOCK) returns to IDLE asynchronously. Timers and counters clear; Autos is lost.
- Timer width = $clog2(max(OPEN_TIMEOUT, LOCK_CYCLES)+1). Widths are elaborated from parameters, with no truncation warnings.

Decomposition:
- Shared package acceso_pkg holds:
  - State one-hot localparams (ST_IDLE..ST_TAILGATE).
  - A function to compute counter widths.
- The sub-module contador_desc (a loadable down-counter with a zero flag, width-parametrised) is natural and is used for both the OPEN and LOCK timers.
- The FSM, input stage and Autos counter stay in the top.

Test Plan:
(Bench parameters: DIGITS=4, CLAVE_VALIDA=16'h0259, MAX_INTENTOS=3, OPEN_TIMEOUT=8, LOCK_CYCLES=16, CNT_W=2.)
- Entrada=1, Clave=16'h0259, Enter pulse; then Salida=1, Entrada=0 -> Abrir=1 two edges after Enter; Cerrar=1 for exactly 1 cycle; Autos=1; back to IDLE.
- Three presses of Clave=16'h1234 -> Intentos 1,2,3; AlrmInt=1 for 16 cycles, then 0, Intentos=0; a correct code entered during LOCK has no effect.
- Correct PIN, no Salida -> Abrir=1 for 8 cycles, then Cerrar pulse; Autos unchanged.
- In OPEN, Salida=1 & Entrada=1 -> AlrmCom=1, Cerrar=1 held; wrong code keeps them; Clave=16'h0259 + Enter -> IDLE with all outputs 0.
- Enter held high for 10 cycles with a wrong code -> Intentos=1 only; 5 admissions -> Autos saturates at 3.
- Reset asserted mid-LOCK and mid-OPEN -> outputs 0 immediately (asynchronous), Intentos=0, Autos=0, state IDLE.
